// File: rtl/assert_sched_pkg.sv
// Shared types and constants for the assertion event scheduler.
package assert_sched_pkg;

    typedef enum logic [1:0] {IDLE, REPORT, WAIT, STOP} state_e;

    localparam int DEF_N_SRC = 8;
    localparam int DEF_CNT_W = 16;

    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

    typedef logic [$clog2(DEF_N_SRC)-1:0] src_idx_t;

endpackage

// File: rtl/assert_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// above ptr, wrapping past the top index back to zero.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_oh,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);
    localparam int IW = $clog2(N);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any     = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/assert_event_scheduler.sv
// Collects assertion failure strobes and serialises them as round-robin reports.
// Define ASSERT_SCHED_FATAL_EN to enable the delayed stop request after a fatal report.
//
// state  | meaning
// IDLE   | no report held; grant next pending source
// REPORT | rpt_valid high, report held until rpt_ready
// WAIT   | fatal report accepted, stop delay counting down
// STOP   | stop_req held until reset, no further reports
module assert_event_scheduler
    import assert_sched_pkg::*;
#(
    parameter int N_SRC      = DEF_N_SRC,
    parameter int CNT_W      = $bits(CNT_MAX),
    parameter int STOP_DELAY = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [N_SRC-1:0]         fail_vec,
    input  logic [N_SRC-1:0]         mask,
    input  logic [N_SRC-1:0]         fatal_mask,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [$clog2(N_SRC)-1:0] rpt_id,
    output logic [CNT_W-1:0]         rpt_count,
    output logic [N_SRC-1:0]         sticky,
    output logic [CNT_W-1:0]         total_count,
    output logic                     stop_req
);
    localparam int ID_W  = $clog2(N_SRC);
    localparam int POP_W = $clog2(N_SRC + 1);
    localparam logic [CNT_W-1:0] SAT     = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_SRC - 1);

    state_e                 state;
    logic [N_SRC-1:0]       pending;
    logic [N_SRC-1:0]       cap;
    logic [N_SRC-1:0]       gnt_oh;
    logic [CNT_W-1:0]       cnt [N_SRC];
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        gnt_idx;
    logic [ID_W-1:0]        next_ptr;
    logic                   gnt_any;
    logic                   grant;
    logic [POP_W-1:0]       cap_pop;
    logic [CNT_W+POP_W-1:0] total_sum;

    assign cap      = fail_vec & ~mask & {N_SRC{enable}};
    assign grant    = (state == IDLE) && gnt_any && !clear;
    assign next_ptr = (rpt_id == LAST_ID) ? '0 : rpt_id + 1'b1;

    always_comb begin
        cap_pop = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cap_pop = cap_pop + POP_W'(cap[i]);
        end
    end

    assign total_sum = {{POP_W{1'b0}}, total_count} + {{CNT_W{1'b0}}, cap_pop};

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req     (pending),
        .ptr     (rr_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // A capture on the granted (or cleared) source in the same cycle starts a fresh count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= '0;
            sticky      <= '0;
            total_count <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (clear || (grant && gnt_oh[i])) begin
                    pending[i] <= cap[i];
                    cnt[i]     <= CNT_W'(cap[i]);
                end else if (cap[i]) begin
                    pending[i] <= 1'b1;
                    if (cnt[i] != SAT) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
                sticky[i] <= (sticky[i] & !clear) | cap[i];
            end
            if (clear) begin
                total_count <= CNT_W'(cap_pop);
            end else if (total_sum[CNT_W+POP_W-1:CNT_W] != '0) begin
                total_count <= SAT;
            end else begin
                total_count <= total_sum[CNT_W-1:0];
            end
        end
    end

`ifdef ASSERT_SCHED_FATAL_EN
    localparam int SD_W = $clog2(STOP_DELAY + 1);
    logic [SD_W-1:0] stop_cnt;
`else
    logic unused_fatal;
    assign unused_fatal = (^fatal_mask) ^ (STOP_DELAY > 0);
    assign stop_req     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rpt_valid <= 1'b0;
            rpt_id    <= '0;
            rpt_count <= '0;
            rr_ptr    <= '0;
`ifdef ASSERT_SCHED_FATAL_EN
            stop_cnt  <= '0;
            stop_req  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        rpt_id    <= gnt_idx;
                        rpt_count <= cnt[gnt_idx];
                        rpt_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
`ifdef ASSERT_SCHED_FATAL_EN
                        if (fatal_mask[rpt_id]) begin
                            state    <= WAIT;
                            stop_cnt <= SD_W'(STOP_DELAY);
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef ASSERT_SCHED_FATAL_EN
                WAIT: begin
                    if (stop_cnt == SD_W'(1)) begin
                        state    <= STOP;
                        stop_req <= 1'b1;
                    end else begin
                        stop_cnt <= stop_cnt - 1'b1;
                    end
                end
                STOP: begin
                    stop_req <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
